// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data memory: port 0 is the core
// load/store path, port 1 the debug/DMA loader. One transaction in flight at a time.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              p0_req_valid_i,
    output logic              p0_req_ready_o,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_rsp_valid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_valid_i,
    output logic              p1_req_ready_o,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_rsp_valid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    // Handshake: a request transfers on a cycle where valid and ready are both
    // high; ready is only raised in IDLE, for the single port being granted.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_next;
    logic              last_grant;
    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic              hs;
    logic              sel;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    always_comb begin
        // On a tie the port that did not win last time is granted.
        p0_req_ready_o = (state == S_IDLE) && p0_req_valid_i && (!p1_req_valid_i || last_grant);
        p1_req_ready_o = (state == S_IDLE) && p1_req_valid_i && (!p0_req_valid_i || !last_grant);
        hs        = p0_req_ready_o || p1_req_ready_o;
        sel       = p1_req_ready_o;
        req_we    = sel ? p1_we_i    : p0_we_i;
        req_addr  = sel ? p1_addr_i  : p0_addr_i;
        req_wdata = sel ? p1_wdata_i : p0_wdata_i;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (hs) state_next = S_ISSUE;
            S_ISSUE: state_next = cmd_we ? S_RESP : S_WAIT;
            S_WAIT:  if (lat_cnt == 3'd0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            cmd_port       <= 1'b0;
            cmd_we         <= 1'b0;
            cmd_addr       <= '0;
            cmd_wdata      <= '0;
            lat_cnt        <= 3'd0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_we_o       <= 1'b0;
            mem_re_o       <= 1'b0;
            p0_rsp_valid_o <= 1'b0;
            p1_rsp_valid_o <= 1'b0;
        end else begin
            state          <= state_next;
            // Strobes are launched from the handshake so they are high exactly in ISSUE.
            mem_we_o       <= hs && req_we;
            mem_re_o       <= hs && !req_we;
            p0_rsp_valid_o <= (state_next == S_RESP) && !cmd_port;
            p1_rsp_valid_o <= (state_next == S_RESP) && cmd_port;
            if (hs) begin
                cmd_port   <= sel;
                cmd_we     <= req_we;
                cmd_addr   <= req_addr;
                cmd_wdata  <= req_wdata;
                last_grant <= sel;
            end
            if (state == S_ISSUE) begin
                lat_cnt <= 3'(READ_LAT - 1);
            end else if (state == S_WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (state == S_WAIT && lat_cnt == 3'd0) begin
                if (cmd_port) rdata1 <= mem_rdata_i;
                else          rdata0 <= mem_rdata_i;
            end
        end
    end

    assign mem_addr_o  = cmd_addr;
    assign mem_wdata_o = cmd_wdata;
    assign p0_rdata_o  = rdata0;
    assign p1_rdata_o  = rdata1;
    assign busy_o      = (state != S_IDLE);
    assign state_o     = state;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data memory between two requesters: port 0 is the core load/store path and port 1 is the debug/DMA loader.
- Round-robin grant with valid/ready handshakes on both request ports.
- All memory-side signals are registered and sequenced by a small FSM; read data returns after a programmable memory latency.
- Sits between the datapath's ALU/store-data outputs and the data_memory instance; the core stalls while its request is not accepted or its response is pending.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 64, data word width.
- READ_LAT, 1, memory clock cycles from read strobe to valid mem_rdata_i; legal range 1..7.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- p0_req_valid_i  in  1  core request valid.
- p0_req_ready_o  out  1  core request accepted when high with valid.
- p0_we_i  in  1  1 = store, 0 = load.
- p0_addr_i  in  ADDR_W  core address.
- p0_wdata_i  in  DATA_W  core store data.
- p0_rsp_valid_o  out  1  one-cycle pulse: load data valid or store done.
- p0_rdata_o  out  DATA_W  core load data.
- p1_req_valid_i, p1_req_ready_o, p1_we_i, p1_addr_i, p1_wdata_i, p1_rsp_valid_o, p1_rdata_o: same as p0, for debug/DMA.
- mem_addr_o  out  ADDR_W  registered memory address.
- mem_wdata_o  out  DATA_W  registered write data.
- mem_we_o  out  1  write strobe, one cycle.
- mem_re_o  out  1  read strobe, one cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; all outputs 0; last_grant = 1, so port 0 wins the first tie.
  - Captured command, latency counter and rdata registers are cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - pN_req_ready_o = 1 only for the port being granted this cycle; it is combinational from the valids and last_grant.
  - Grant rules:
    - Only one valid: grant that port.
    - Both valid: grant the port != last_grant.
    - None valid: stay in IDLE.
  - On handshake (valid & ready): capture we/addr/wdata and the port id, update last_grant to that port, go to ISSUE.
- ISSUE, exactly one cycle:
  - mem_addr_o/mem_wdata_o = captured values.
  - mem_we_o = captured we; mem_re_o = ~captured we.
  - Store: go to RESP.
  - Load: load counter = READ_LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle; strobes are low; mem_addr_o is held.
  - When the counter is 0, capture mem_rdata_i into the granted port's rdata register and go to RESP.
  - READ_LAT=1 means capture happens in the first WAIT cycle.
- RESP, one cycle:
  - Granted pN_rsp_valid_o = 1.
  - pN_rdata_o holds the load data; for a store it holds the previous value, unchanged.
  - Go to IDLE.
  - The non-granted port's rsp_valid stays 0.
- Latency, handshake to rsp_valid:
  - Store: 2 cycles.
  - Load: 2 + READ_LAT cycles.
  - Earliest next handshake is the cycle after RESP.
- Ready is low in ISSUE/WAIT/RESP.
- A requester holds valid and payload stable until ready; dropping valid before ready is legal and cancels the request with no side effects.
- pN_rdata_o holds its value until that port's next load response.
- Simultaneous valids: strict alternation while both stay asserted; neither port waits more than one transaction.
- Address/data are not interpreted; there is no wrap-around or width conversion (pass-through).
- Reset mid-transaction: everything returns to IDLE immediately and in-flight strobes drop asynchronously. The interrupted request gets no response and the requester re-issues it.
- busy_o = (state != IDLE).

Test Plan:
- Reset then idle: rst_ni low for 3 cycles → all outputs 0, busy_o=0; first cycle after release with both valid → p0_req_ready_o=1, p1_req_ready_o=0.
- Core store then load, READ_LAT=1:
  - p0 store addr 0x10, data 0xDEADBEEF_00000001 → one cycle later mem_we_o=1, mem_addr_o=0x10; p0_rsp_valid_o 2 cycles after handshake.
  - p0 load 0x10 with memory returning that value → p0_rdata_o=0xDEADBEEF_00000001, p0_rsp_valid_o 3 cycles after handshake.
- Contention: both ports hold valid loads for 4 transactions → grant order p0,p1,p0,p1; each rsp_valid only on its own port; p1_rdata_o unchanged during p0 responses.
- READ_LAT=4: p1 load addr 0xFF → mem_re_o pulses once, busy_o high for 6 cycles, p1_rsp_valid_o exactly 6 cycles after handshake; no ready during that window.
- Reset mid-WAIT: assert rst_ni low during a p0 load's WAIT → outputs 0 within the same cycle, no p0_rsp_valid_o after release, next p0 request is serviced normally.
- Withdrawn request: p1 valid during a busy p0 transaction, then deasserted before IDLE → no p1 handshake, no memory access for p1, last_grant stays 0.
